// File: rtl/rf_wport_arb.sv
// rf_wport_arb: shares the single register-file write port between two writers.
//   Port A (in-order writeback) has fixed priority; port B (long-latency unit) is
//   forced through after MAX_WAIT consecutive refusals. One registered stage
//   drives the RF write port (latency 1, never back-pressures).
//
// Optional feature macro: RF_ARB_SCOREBOARD_EN
//   defined     -> 32-entry pending scoreboard for registers awaiting a B write
//   not defined -> o_pending tied to zero, i_lock_* ignored
//
// Ports:
//   i_clk, i_rst_n                 clock, asynchronous active-low reset
//   i_a_valid/o_a_ready/i_a_addr/i_a_data   port A write request handshake
//   i_b_valid/o_b_ready/i_b_addr/i_b_data   port B write request handshake
//   i_lock_en/i_lock_addr          mark a register pending on B-op issue
//   o_pending                      registered pending bitmap (bit 0 always 0)
//   o_rd_wen/o_rd_waddr/o_rd_wdata registered RF write port
//   o_a_ready/o_b_ready are combinational.

module rf_wport_arb #(
  parameter int unsigned MAX_WAIT = 3,
  parameter int unsigned CNT_W    = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_a_valid,
  output logic        o_a_ready,
  input  logic [4:0]  i_a_addr,
  input  logic [31:0] i_a_data,
  input  logic        i_b_valid,
  output logic        o_b_ready,
  input  logic [4:0]  i_b_addr,
  input  logic [31:0] i_b_data,
  input  logic        i_lock_en,
  input  logic [4:0]  i_lock_addr,
  output logic [31:0] o_pending,
  output logic        o_rd_wen,
  output logic [4:0]  o_rd_waddr,
  output logic [31:0] o_rd_wdata
);

  localparam int unsigned AW   = 5;
  localparam int unsigned DW   = 32;
  localparam int unsigned NREG = 32;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             starve;
  logic             a_xfer;
  logic             b_xfer;
  logic             wen_d;
  logic [AW-1:0]    waddr_d;
  logic [DW-1:0]    wdata_d;

  // Arbitration: A wins unless B has been refused MAX_WAIT cycles in a row.
  always_comb begin
    starve    = (cnt_q == CNT_W'(MAX_WAIT));
    o_a_ready = !(i_b_valid && starve);
    o_b_ready = !i_a_valid || starve;
    a_xfer    = i_a_valid && o_a_ready;
    b_xfer    = i_b_valid && o_b_ready;
  end

  // Starvation counter: counts refused B cycles, saturating at MAX_WAIT.
  always_comb begin
    cnt_d = cnt_q;
    if (!i_b_valid || b_xfer) begin
      cnt_d = '0;
    end else if (!starve) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Write stage next value; x0 destinations complete the handshake but never write.
  always_comb begin
    wen_d   = 1'b0;
    waddr_d = o_rd_waddr;
    wdata_d = o_rd_wdata;
    if (a_xfer) begin
      wen_d   = (i_a_addr != '0);
      waddr_d = i_a_addr;
      wdata_d = i_a_data;
    end else if (b_xfer) begin
      wen_d   = (i_b_addr != '0);
      waddr_d = i_b_addr;
      wdata_d = i_b_data;
    end
  end

  // Counter and write-stage registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q      <= '0;
      o_rd_wen   <= 1'b0;
      o_rd_waddr <= '0;
      o_rd_wdata <= '0;
    end else begin
      cnt_q      <= cnt_d;
      o_rd_wen   <= wen_d;
      o_rd_waddr <= waddr_d;
      o_rd_wdata <= wdata_d;
    end
  end

`ifdef RF_ARB_SCOREBOARD_EN
  logic [NREG-1:0] pend_q;
  logic [NREG-1:0] pend_d;

  // Clear on B completion first, then set on new issue so a same-cycle lock wins.
  always_comb begin
    pend_d = pend_q;
    if (b_xfer) begin
      pend_d[i_b_addr] = 1'b0;
    end
    if (i_lock_en && (i_lock_addr != '0)) begin
      pend_d[i_lock_addr] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  assign o_pending = pend_q;
`else
  // Lock inputs have no consumer in this build.
  logic unused_lock;
  assign unused_lock = &{1'b0, i_lock_en, i_lock_addr};
  assign o_pending   = NREG'(0);
`endif

endmodule

// File: tb/tb_rf_wport_arb.sv
// Directed, table-driven bench for rf_wport_arb plus a reset-mid-transfer sequence.
module tb_rf_wport_arb;

`ifdef RF_ARB_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        a_valid, b_valid, lock_en;
  logic [4:0]  a_addr, b_addr, lock_addr;
  logic [31:0] a_data, b_data;
  logic        a_ready, b_ready;
  logic [31:0] pending;
  logic        wen;
  logic [4:0]  waddr;
  logic [31:0] wdata;

  int checks = 0;
  int errors = 0;

  rf_wport_arb #(.MAX_WAIT(3), .CNT_W(2)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_a_valid   (a_valid),
    .o_a_ready   (a_ready),
    .i_a_addr    (a_addr),
    .i_a_data    (a_data),
    .i_b_valid   (b_valid),
    .o_b_ready   (b_ready),
    .i_b_addr    (b_addr),
    .i_b_data    (b_data),
    .i_lock_en   (lock_en),
    .i_lock_addr (lock_addr),
    .o_pending   (pending),
    .o_rd_wen    (wen),
    .o_rd_waddr  (waddr),
    .o_rd_wdata  (wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        av;
    logic [4:0]  aa;
    logic [31:0] ad;
    logic        bv;
    logic [4:0]  ba;
    logic [31:0] bd;
    logic        lk;
    logic [4:0]  la;
    logic        ar;
    logic        br;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] pend;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  function automatic vec_t mk(logic av, logic [4:0] aa, logic [31:0] ad,
                              logic bv, logic [4:0] ba, logic [31:0] bd,
                              logic lk, logic [4:0] la,
                              logic ar, logic br, logic w, logic [4:0] wa,
                              logic [31:0] wd, logic [31:0] pe);
    vec_t v;
    v.av = av; v.aa = aa; v.ad = ad;
    v.bv = bv; v.ba = ba; v.bd = bd;
    v.lk = lk; v.la = la;
    v.ar = ar; v.br = br; v.wen = w; v.waddr = wa; v.wdata = wd; v.pend = pe;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                       input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                       input logic lk, input logic [4:0] la);
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    lock_en = lk; lock_addr = la;
  endtask

  initial begin
    //            av aa    ad            bv ba     bd        lk la     ar br wen wa     wdata         pend
    vecs[0]  = mk(0, 5'd0, 32'h0,        0, 5'd0,  32'h0,    0, 5'd0,  1, 1, 0, 5'd0,  32'h0,        32'h0);
    vecs[1]  = mk(1, 5'd5, 32'hDEADBEEF, 0, 5'd0,  32'h0,    0, 5'd0,  1, 0, 1, 5'd5,  32'hDEADBEEF, 32'h0);
    vecs[2]  = mk(1, 5'd0, 32'h1234,     0, 5'd0,  32'h0,    0, 5'd0,  1, 0, 0, 5'd0,  32'h1234,     32'h0);
    vecs[3]  = mk(0, 5'd0, 32'h0,        1, 5'd9,  32'h99,   0, 5'd0,  1, 1, 1, 5'd9,  32'h99,       32'h0);
    vecs[4]  = mk(0, 5'd0, 32'h0,        0, 5'd0,  32'h0,    1, 5'd7,  1, 1, 0, 5'd9,  32'h99,       32'h80);
    vecs[5]  = mk(1, 5'd1, 32'h11,       1, 5'd7,  32'h77,   0, 5'd0,  1, 0, 1, 5'd1,  32'h11,       32'h80);
    vecs[6]  = mk(1, 5'd1, 32'h11,       1, 5'd7,  32'h77,   0, 5'd0,  1, 0, 1, 5'd1,  32'h11,       32'h80);
    vecs[7]  = mk(1, 5'd1, 32'h11,       1, 5'd7,  32'h77,   0, 5'd0,  1, 0, 1, 5'd1,  32'h11,       32'h80);
    vecs[8]  = mk(1, 5'd1, 32'h11,       1, 5'd7,  32'h77,   0, 5'd0,  0, 1, 1, 5'd7,  32'h77,       32'h0);
    vecs[9]  = mk(1, 5'd2, 32'h22,       0, 5'd0,  32'h0,    0, 5'd0,  1, 0, 1, 5'd2,  32'h22,       32'h0);
    vecs[10] = mk(0, 5'd0, 32'h0,        1, 5'd7,  32'h70,   1, 5'd7,  1, 1, 1, 5'd7,  32'h70,       32'h80);
    vecs[11] = mk(0, 5'd0, 32'h0,        0, 5'd0,  32'h0,    1, 5'd0,  1, 1, 0, 5'd7,  32'h70,       32'h80);
    vecs[12] = mk(0, 5'd0, 32'h0,        1, 5'd3,  32'h33,   0, 5'd0,  1, 1, 1, 5'd3,  32'h33,       32'h80);
    vecs[13] = mk(1, 5'd7, 32'hA7,       0, 5'd0,  32'h0,    0, 5'd0,  1, 0, 1, 5'd7,  32'hA7,       32'h80);
    vecs[14] = mk(1, 5'd4, 32'h44,       1, 5'd8,  32'h88,   0, 5'd0,  1, 0, 1, 5'd4,  32'h44,       32'h80);
    vecs[15] = mk(1, 5'd4, 32'h44,       1, 5'd8,  32'h88,   0, 5'd0,  1, 0, 1, 5'd4,  32'h44,       32'h80);
    vecs[16] = mk(1, 5'd4, 32'h44,       1, 5'd8,  32'h88,   0, 5'd0,  1, 0, 1, 5'd4,  32'h44,       32'h80);
    vecs[17] = mk(0, 5'd0, 32'h0,        1, 5'd8,  32'h88,   0, 5'd0,  0, 1, 1, 5'd8,  32'h88,       32'h80);
    vecs[18] = mk(1, 5'd5, 32'h55,       1, 5'd6,  32'h66,   0, 5'd0,  1, 0, 1, 5'd5,  32'h55,       32'h80);
    vecs[19] = mk(0, 5'd0, 32'h0,        0, 5'd0,  32'h0,    0, 5'd0,  1, 1, 0, 5'd5,  32'h55,       32'h80);
    vecs[20] = mk(1, 5'd5, 32'h55,       1, 5'd6,  32'h66,   0, 5'd0,  1, 0, 1, 5'd5,  32'h55,       32'h80);

    // Reset state
    rst_n = 1'b0;
    drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0);
    #1;
    check("reset_wen",     32'(wen),     32'h0);
    check("reset_waddr",   32'(waddr),   32'h0);
    check("reset_wdata",   wdata,        32'h0);
    check("reset_pending", pending,      32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table vectors: readies mid-cycle, registered outputs just after the edge.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i].av, vecs[i].aa, vecs[i].ad, vecs[i].bv, vecs[i].ba, vecs[i].bd,
            vecs[i].lk, vecs[i].la);
      #1;
      check($sformatf("v%0d_a_ready", i), 32'(a_ready), 32'(vecs[i].ar));
      check($sformatf("v%0d_b_ready", i), 32'(b_ready), 32'(vecs[i].br));
      @(posedge clk);
      #1;
      check($sformatf("v%0d_wen", i),     32'(wen),   32'(vecs[i].wen));
      check($sformatf("v%0d_waddr", i),   32'(waddr), 32'(vecs[i].waddr));
      check($sformatf("v%0d_wdata", i),   wdata,      vecs[i].wdata);
      check($sformatf("v%0d_pending", i), pending,    SB ? vecs[i].pend : 32'h0);
    end

    // Reset asserted during an accept cycle: outputs clear at once, nothing written later.
    @(negedge clk);
    drive(1, 5'd10, 32'hAA, 1, 5'd11, 32'hBB, 1, 5'd12);
    #1;
    check("rst_seq_a_ready_before", 32'(a_ready), 32'h1);
    check("rst_seq_wen_before",     32'(wen),     32'h1);
    rst_n = 1'b0;
    #1;
    check("rst_async_wen",     32'(wen),   32'h0);
    check("rst_async_waddr",   32'(waddr), 32'h0);
    check("rst_async_pending", pending,    32'h0);
    @(posedge clk);
    #1;
    check("rst_hold_wen",   32'(wen), 32'h0);
    check("rst_hold_wdata", wdata,    32'h0);
    @(negedge clk);
    drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_no_write", 32'(wen), 32'h0);
    check("post_rst_pending",  pending,  32'h0);

    // Counter must restart from zero: A wins three times before B is forced.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(1, 5'd12, 32'hC0, 1, 5'd13, 32'hD0, 0, 5'd0);
      #1;
      check($sformatf("post_rst_c%0d_a_ready", i), 32'(a_ready), (i < 3) ? 32'h1 : 32'h0);
      check($sformatf("post_rst_c%0d_b_ready", i), 32'(b_ready), (i < 3) ? 32'h0 : 32'h1);
      @(posedge clk);
      #1;
      check($sformatf("post_rst_c%0d_waddr", i), 32'(waddr), (i < 3) ? 32'd12 : 32'd13);
    end

    @(negedge clk);
    drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
